// File: rtl/key_pio_pkg.sv
// Shared definitions for the debounced key PIO: register map and counter sizing.
package key_pio_pkg;

    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    // Avalon-MM register map (word addresses).
    localparam addr_t ADDR_DATA         = 3'd0;
    localparam addr_t ADDR_RAW          = 3'd1;
    localparam addr_t ADDR_IRQ_MASK     = 3'd2;
    localparam addr_t ADDR_EDGE_CAPTURE = 3'd3;
    localparam addr_t ADDR_RISE_EN      = 3'd4;
    localparam addr_t ADDR_FALL_EN      = 3'd5;

    // Width of the debounce counter; never narrower than one bit so the
    // declaration stays legal for tiny cycle counts.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser, stability counter and accepted level.
// Rise/fall pulses are combinational and high exactly on the edge where the
// accepted level changes, so capture logic can register them on that same edge.
module key_debounce
    import key_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_sync,
    output logic o_stable,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;
    logic w_update;

    // Bring the asynchronous key input into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            // NOTE: non-blocking assignments let r_sync2 take the old r_sync1, forming two real flops.
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // Debounce disabled: accept any difference on the next edge.
            assign w_update = (r_sync2 != r_stable);
        end else begin : g_count
            localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_count;

            // Count consecutive cycles the synchronised input differs from the
            // accepted level; any return to the accepted level restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_count <= '0;
                end else if ((r_sync2 == r_stable) || w_update) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            assign w_update = (r_sync2 != r_stable) && (r_count == CNT_LAST);
        end
    endgenerate

    // Accept the new level once it has been held long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= IDLE_LEVEL;
        end else if (w_update) begin
            r_stable <= r_sync2;
        end
    end

    assign o_sync       = r_sync2;
    assign o_stable     = r_stable;
    assign o_rise_pulse = w_update &  r_sync2;
    assign o_fall_pulse = w_update & ~r_sync2;

endmodule

// File: rtl/key_pio_debounced.sv
// Avalon-MM key/switch PIO with per-channel debounce, selectable edge capture
// (write-1-to-clear, new edges win over clears) and a level interrupt.
module key_pio_debounced
    import key_pio_pkg::*;
#(
    parameter int               WIDTH           = 3,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_events;
    logic [WIDTH-1:0] w_ec_clear;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_read_value;
    logic             w_write;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [31:0]      r_readdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL      (IDLE_LEVEL[gi])
            ) u_debounce (
                .clk          (clk),
                .reset_n      (reset_n),
                .i_raw        (in_port[gi]),
                .o_sync       (w_raw[gi]),
                .o_stable     (w_stable[gi]),
                .o_rise_pulse (w_rise[gi]),
                .o_fall_pulse (w_fall[gi])
            );
        end
    endgenerate

    assign w_write        = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    // Edge enables are sampled as they stand before the write edge, so an
    // enable change only affects transitions completing afterwards.
    assign w_events   = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_ec_clear = (w_write && (address == ADDR_EDGE_CAPTURE)) ? w_wdata : '0;

    // Software-writable control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '1;
        end else if (w_write) begin
            case (address)
                ADDR_IRQ_MASK: r_irq_mask <= w_wdata;
                ADDR_RISE_EN:  r_rise_en  <= w_wdata;
                ADDR_FALL_EN:  r_fall_en  <= w_wdata;
                default:       ;
            endcase
        end
    end

    // Edge capture: clear first, then OR in new events so a simultaneous set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_capture <= '0;
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_ec_clear) | w_events;
        end
    end

    // Read mux; unmapped addresses and unused upper bits return zero.
    always_comb begin
        // NOTE: default first so every path assigns w_read_value and no latch is inferred.
        w_read_value = '0;
        case (address)
            ADDR_DATA:         w_read_value[WIDTH-1:0] = w_stable;
            ADDR_RAW:          w_read_value[WIDTH-1:0] = w_raw;
            ADDR_IRQ_MASK:     w_read_value[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAPTURE: w_read_value[WIDTH-1:0] = r_edge_capture;
            ADDR_RISE_EN:      w_read_value[WIDTH-1:0] = r_rise_en;
            ADDR_FALL_EN:      w_read_value[WIDTH-1:0] = r_fall_en;
            default:           ;
        endcase
    end

    // Register read data every cycle; reads need no chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_read_value;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_key_pio_debounced.sv
// Scoreboard bench for key_pio_debounced: one instance with a 4-cycle debounce
// and one with debounce bypassed, sharing the bus but with separate keys.
module tb_key_pio_debounced;
    import key_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  in_a;
    logic [2:0]  in_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    always #5 clk = ~clk;

    key_pio_debounced #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (4),
        .IDLE_LEVEL      (3'b111)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_a),
        .in_port    (in_a),
        .irq        (irq_a)
    );

    key_pio_debounced #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (0),
        .IDLE_LEVEL      (3'b111)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_b),
        .in_port    (in_b),
        .irq        (irq_b)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          sel;   // 0: dut_a, 1: dut_b
    } exp_t;

    exp_t q_rd[$];
    exp_t q_irq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic rd_issue  = 1'b0;
    logic rd_valid  = 1'b0;
    logic irq_issue = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read data appears one cycle after the address is presented.
    always @(posedge clk) rd_valid <= rd_issue;

    // Monitor: compare DUT outputs against the scoreboard when they are presented.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (q_rd.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_underflow: read data presented with nothing queued");
            end else begin
                e = q_rd.pop_front();
                check(e.name, e.sel ? rd_b : rd_a, e.exp);
            end
        end
        if (irq_issue) begin
            if (q_irq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL irq_underflow: irq sample with nothing queued");
            end else begin
                e = q_irq.pop_front();
                check(e.name, {31'd0, (e.sel ? irq_b : irq_a)}, e.exp);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        e.sel  = sel;
        q_rd.push_back(e);
        address  = a;
        rd_issue = 1'b1;
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Sample irq in the current cycle (state after the most recent edge).
    task automatic chk_irq(input bit sel, input logic exp, input string name);
        exp_t e;
        e.name = name;
        e.exp  = {31'd0, exp};
        e.sel  = sel;
        q_irq.push_back(e);
        irq_issue = 1'b1;
        tick();
        irq_issue = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = 3'b111;
        in_b       = 3'b111;
        tick(2);

        // Reset state.
        rd(1'b0, ADDR_DATA, 32'h0, "reset_readdata_a");
        rd(1'b1, ADDR_DATA, 32'h0, "reset_readdata_b");
        chk_irq(1'b0, 1'b0, "reset_irq_a");
        chk_irq(1'b1, 1'b0, "reset_irq_b");
        reset_n = 1'b1;
        tick(2);
        rd(1'b0, ADDR_DATA,     32'h7, "data_idle");
        rd(1'b0, ADDR_FALL_EN,  32'h7, "fall_en_reset");
        rd(1'b0, ADDR_RISE_EN,  32'h0, "rise_en_reset");
        rd(1'b0, ADDR_IRQ_MASK, 32'h0, "irq_mask_reset");
        rd(1'b1, ADDR_DATA,     32'h7, "data_idle_b");

        // Key 0 press: edge lands exactly 1+4 edges after the first sampling edge.
        wr(ADDR_IRQ_MASK, 32'h1);
        in_a = 3'b110;
        tick(5);
        chk_irq(1'b0, 1'b0, "irq_before_debounce");
        chk_irq(1'b0, 1'b1, "irq_after_debounce");
        rd(1'b0, ADDR_DATA,         32'h6, "data_key0_pressed");
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h1, "ec_key0_fall");
        chk_irq(1'b1, 1'b0, "irq_b_quiet");

        // Three-cycle glitch on key 1: visible on RAW, rejected by debounce.
        in_a = 3'b100;
        tick(2);
        rd(1'b0, ADDR_RAW, 32'h4, "raw_glitch");
        in_a = 3'b110;
        tick(8);
        rd(1'b0, ADDR_DATA,         32'h6, "data_after_glitch");
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h1, "ec_after_glitch");
        chk_irq(1'b0, 1'b1, "irq_before_clear");
        wr(ADDR_EDGE_CAPTURE, 32'h1);
        chk_irq(1'b0, 1'b0, "irq_after_clear");

        // Rise-only capture on key 2.
        wr(ADDR_RISE_EN, 32'h4);
        wr(ADDR_FALL_EN, 32'h0);
        in_a = 3'b010;
        tick(10);
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h0, "ec_press_ignored");
        rd(1'b0, ADDR_DATA,         32'h2, "data_key2_pressed");
        in_a = 3'b110;
        tick(10);
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h4, "ec_release");
        wr(ADDR_IRQ_MASK, 32'h4);
        chk_irq(1'b0, 1'b1, "irq_release");
        wr(ADDR_EDGE_CAPTURE, 32'h4);
        chk_irq(1'b0, 1'b0, "irq_drop_after_clear");
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h0, "ec_cleared");

        // Set and clear on the same edge: the new edge wins.
        wr(ADDR_FALL_EN, 32'h7);
        in_a = 3'b111;
        tick(10);
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h0, "ec_rise_masked_ch0");
        rd(1'b0, ADDR_DATA,         32'h7, "data_all_released");
        in_a = 3'b110;
        tick(5);
        wr(ADDR_EDGE_CAPTURE, 32'h1);
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h1, "ec_set_wins");
        wr(ADDR_EDGE_CAPTURE, 32'h1);
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h0, "ec_cleared_after_collision");

        // Reset in the middle of a key 1 debounce count.
        in_a = 3'b100;
        tick(3);
        reset_n = 1'b0;
        in_a    = 3'b111;
        tick(2);
        rd(1'b0, ADDR_DATA, 32'h0, "reset_mid_readdata");
        reset_n = 1'b1;
        tick(1);
        rd(1'b0, ADDR_DATA, 32'h7, "data_after_reset");
        wr(ADDR_IRQ_MASK, 32'h7);
        tick(10);
        rd(1'b0, ADDR_EDGE_CAPTURE, 32'h0, "ec_after_reset");
        rd(1'b0, ADDR_DATA,         32'h7, "data_settled_after_reset");
        chk_irq(1'b0, 1'b0, "irq_after_reset");

        // Bypassed debounce: capture two edges after the first sampling edge.
        wr(ADDR_IRQ_MASK, 32'h2);
        in_b = 3'b101;
        tick(2);
        chk_irq(1'b1, 1'b0, "irq_b_before_edge");
        chk_irq(1'b1, 1'b1, "irq_b_edge");
        rd(1'b1, ADDR_EDGE_CAPTURE, 32'h2, "ec_b_fall");
        rd(1'b1, ADDR_DATA,         32'h5, "data_b_pressed");
        chk_irq(1'b0, 1'b0, "irq_a_quiet");

        tick(3);
        n_checks++;
        if ((q_rd.size() != 0) || (q_irq.size() != 0)) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d reads and %0d irq samples left, expected 0",
                     q_rd.size(), q_irq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_pio_debounced.md
# key_pio_debounced

Parametrised Avalon-MM key/switch input port for the traffic light controller's Qsys system. It is the successor to the fixed 3-bit key PIO and adds these features:
- configurable channel count;
- two-flop synchronisation;
- per-channel debounce;
- software-selectable rising/falling/both edge capture;
- write-1-to-clear capture, where new edges win over clears.

It sits on the Nios II data master and drives one level interrupt line.

## Interface
- WIDTH, 3, number of input channels, 1..32
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level is accepted (10 ms at 50 MHz); 0 bypasses debounce
- IDLE_LEVEL, all ones, reset value of the debounced state per channel (DE2 keys are active-low)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data, bits [WIDTH-1:0] used
- readdata  out  32  registered read data, upper bits zero
- in_port  in  WIDTH  raw asynchronous key inputs
- irq  out  1  level interrupt, active-high

## Operation
- Register map:
  - 0 DATA (RO, debounced state);
  - 1 RAW (RO, synchronised input);
  - 2 IRQ_MASK (RW);
  - 3 EDGE_CAPTURE (write 1 to clear per bit);
  - 4 RISE_EN (RW);
  - 5 FALL_EN (RW);
  - 6, 7 read 0.
- Writes to RO or unmapped addresses are ignored.
- A write occurs when chipselect && !write_n. Reads need no chipselect: readdata is re-registered every cycle from address.
- Synchroniser: two flops per channel (sync1, sync2). Both reset to IDLE_LEVEL.
- Debounce, per channel:
  - counter width is clog2(DEBOUNCE_CYCLES+1);
  - if sync2 == stable, the counter clears;
  - otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears;
  - any bounce back to the stable level restarts the count from 0.
- Edge event for bit i:
  - rise = stable updating 0->1 and RISE_EN[i];
  - fall = stable updating 1->0 and FALL_EN[i].
- EDGE_CAPTURE[i] is set by an edge event. A write of 1 to bit i clears it.
- If a set and a clear hit the same bit on the same edge, the set wins.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from flops.
- Reset values:
  - readdata 0, irq 0;
  - IRQ_MASK 0, EDGE_CAPTURE 0;
  - RISE_EN 0, FALL_EN all ones;
  - counters 0, stable and syncs IDLE_LEVEL.
- Reset asserted mid-count discards the pending transition. No edge is reported for it.

## Timing
- in_port change settling before edge E reaches sync2 at edge E+1.
- stable and EDGE_CAPTURE update at edge E+1+DEBOUNCE_CYCLES. irq rises in the same cycle.
- DEBOUNCE_CYCLES = 0: stable follows sync2 with one flop of delay. EDGE_CAPTURE sets on the same edge as stable.
- Read latency is 1 cycle. Address presented at edge N gives readdata valid after edge N+1. No wait states.
- A write to IRQ_MASK or EDGE_CAPTURE takes effect at the same edge. irq reflects it in the following cycle.
- RISE_EN/FALL_EN changes apply to transitions that complete after the write edge.

## Structure
- Package key_pio_pkg holds:
  - register address constants: ADDR_DATA, ADDR_RAW, ADDR_IRQ_MASK, ADDR_EDGE_CAPTURE, ADDR_RISE_EN, ADDR_FALL_EN;
  - the counter-width function.
- Sub-module key_debounce: one channel containing sync flops, counter and stable level. It outputs stable, rise_pulse and fall_pulse, and has parameters DEBOUNCE_CYCLES and IDLE_LEVEL bit.
- The top level instantiates key_debounce WIDTH times via generate and owns the registers, read mux and irq.

## Test plan
- Reset with WIDTH=3, DEBOUNCE_CYCLES=4 -> readdata 0, irq 0. Read DATA -> 0x7. Read FALL_EN -> 0x7, RISE_EN -> 0x0.
- Set IRQ_MASK=0x1, drive in_port[0] 1->0 and hold -> DATA bit 0 clears and EDGE_CAPTURE=0x1 exactly 5 edges after sync. irq=1.
- Toggle in_port[1] low for 3 cycles then high -> no DATA change, EDGE_CAPTURE stays 0, RAW shows the glitch.
- Set RISE_EN=0x4, FALL_EN=0x0, press and release key 2 -> only the release sets EDGE_CAPTURE bit 2. Write 0x4 to EDGE_CAPTURE -> bit clears, irq drops next cycle.
- Write 1 to EDGE_CAPTURE bit 0 on the same edge a new falling edge completes on channel 0 -> bit 0 remains 1.
- Assert reset_n mid-debounce count -> no edge captured, DATA returns to 0x7. DEBOUNCE_CYCLES=0 build -> edge captured 2 edges after in_port change.
